// File: rtl/mips_pkg.sv
// Shared types and helpers for the memory access stage.
//   mem_op_t : memory operation code carried from decode/execute
//   state_t  : stage sequencing state
//   mreq_t   : op context captured while a bus access is outstanding
package mips_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [3:0] {
    NONE = 4'd0, LW, LH, LHU, LB, LBU, SW, SH, SB
  } mem_op_t;

  typedef enum logic [1:0] {IDLE, BUS, HOLD} state_t;

  typedef struct packed {
    mem_op_t    op;
    logic [1:0] ofs;
    logic [4:0] rd;
    logic       regwrite;
  } mreq_t;

  function automatic logic is_load(mem_op_t op);
    case (op)
      LW, LH, LHU, LB, LBU: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(mem_op_t op);
    case (op)
      SW, SH, SB: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Word ops need a 4-byte aligned address, halfword ops a 2-byte one.
  function automatic logic is_misaligned(mem_op_t op, logic [1:0] a);
    case (op)
      LW, SW:      return a != 2'b00;
      LH, LHU, SH: return a[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering (combinational).
//   st_op/st_ofs/st_wdata -> st_be/st_data : byte enables and lane-replicated
//                                             store data for the bus
//   ld_op/ld_ofs/ld_rdata -> ld_data       : selected lane extracted and
//                                             sign/zero extended
// Loads enable all four lanes; the lane is picked on the return path.
module mem_lane_align
  import mips_pkg::*;
(
  input  mem_op_t     st_op,
  input  logic [1:0]  st_ofs,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  mem_op_t     ld_op,
  input  logic [1:0]  ld_ofs,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [NUM_LANES-1:0][LANE_W-1:0] st_lanes;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LN   = 2'(i);
    localparam int         HOFS = (i % 2) * LANE_W;

    assign st_be[i] = (st_op == SW) | is_load(st_op) |
                      ((st_op == SH) & (st_ofs[1] == LN[1])) |
                      ((st_op == SB) & (st_ofs == LN));

    // Replicate the byte/halfword into every lane so the enabled lane
    // always carries the right value regardless of offset.
    assign st_lanes[i] = (st_op == SB) ? st_wdata[7:0] :
                         (st_op == SH) ? st_wdata[HOFS +: LANE_W] :
                                         st_wdata[i*LANE_W +: LANE_W];
  end

  assign st_data = st_lanes;

  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  always_comb begin
    lbyte = ld_rdata[{ld_ofs, 3'b000} +: 8];
    lhalf = ld_ofs[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_op)
      LB:      ld_data = {{24{lbyte[7]}}, lbyte};
      LBU:     ld_data = {24'h0, lbyte};
      LH:      ld_data = {{16{lhalf[15]}}, lhalf};
      LHU:     ld_data = {16'h0, lhalf};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access stage behind the execute ALU.
//   in_*    : op from execute (valid/ready); in_alu_y is the address for
//             memory ops or the result for NONE
//   mem_*   : req/ack data bus; request held until mem_ack
//   out_*   : registered writeback result (valid/ready), out_misalign flags
//             an address exception (no bus cycle was issued)
// One op in flight: a bus access or an unconsumed result stalls in_ready.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  mem_op_t       in_op,
  input  logic [AW-1:0] in_alu_y,
  input  logic [DW-1:0] in_wdata,
  input  logic [4:0]    in_rd,
  input  logic          in_regwrite,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [4:0]    out_rd,
  output logic          out_regwrite,
  output logic          out_misalign
);

  state_t      state;
  mreq_t       cap;
  logic        xfer;
  logic        is_mem;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  assign in_ready = (state == IDLE) & (~out_valid | out_ready);
  assign xfer     = in_valid & in_ready;
  assign is_mem   = is_load(in_op) | is_store(in_op);

  mem_lane_align u_align (
    .st_op    (in_op),
    .st_ofs   (in_alu_y[1:0]),
    .st_wdata (in_wdata),
    .st_be    (st_be),
    .st_data  (st_data),
    .ld_op    (cap.op),
    .ld_ofs   (cap.ofs),
    .ld_rdata (mem_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cap          <= '{op: NONE, ofs: 2'b00, rd: 5'd0, regwrite: 1'b0};
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
      out_misalign <= 1'b0;
    end else begin
      // Consume first; a result loaded below in the same cycle wins.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (xfer) begin
            if (!is_mem) begin
              out_valid    <= 1'b1;
              out_data     <= DW'(in_alu_y);
              out_rd       <= in_rd;
              out_regwrite <= in_regwrite;
              out_misalign <= 1'b0;
            end else if (is_misaligned(in_op, in_alu_y[1:0])) begin
              out_valid    <= 1'b1;
              out_data     <= DW'(in_alu_y);
              out_rd       <= in_rd;
              out_regwrite <= 1'b0;
              out_misalign <= 1'b1;
            end else begin
              cap       <= '{op: in_op, ofs: in_alu_y[1:0], rd: in_rd,
                             regwrite: in_regwrite};
              mem_req   <= 1'b1;
              mem_we    <= is_store(in_op);
              mem_addr  <= {in_alu_y[AW-1:2], 2'b00};
              mem_be    <= st_be;
              mem_wdata <= DW'(st_data);
              state     <= BUS;
            end
          end
        end
        BUS: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            out_valid    <= 1'b1;
            out_data     <= is_load(cap.op) ? DW'(ld_data) : '0;
            out_rd       <= cap.rd;
            out_regwrite <= is_load(cap.op) & cap.regwrite;
            out_misalign <= 1'b0;
            state        <= out_ready ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  mem_op_t     in_op = NONE;
  logic [31:0] in_alu_y = '0, in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        in_regwrite = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_regwrite, out_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_alu_y(in_alu_y), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_regwrite(in_regwrite),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_regwrite(out_regwrite), .out_misalign(out_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (architectural rules) ----------------
  typedef struct {
    mem_op_t     op;
    logic [31:0] a, wd;
    logic [4:0]  rd;
    logic        rw;
  } op_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        rw, mis, dchk;
  } res_t;

  op_t  pend_q[$];
  res_t res_q[$];

  function automatic bit ref_mem(mem_op_t op);
    return (op >= LW) && (op <= SB);
  endfunction

  function automatic bit ref_misal(mem_op_t op, logic [31:0] a);
    if (op == LW || op == SW) return (a % 4) != 0;
    if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
    return 0;
  endfunction

  function automatic logic [3:0] ref_be(mem_op_t op, logic [31:0] a);
    int k = a % 4;
    if (op == SB) return 4'(1 << k);
    if (op == SH) return 4'(3 << k);
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wd(mem_op_t op, logic [31:0] wd);
    if (op == SB) return (wd & 32'hFF) * 32'h0101_0101;
    if (op == SH) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_ld(mem_op_t op, logic [31:0] a, logic [31:0] rd);
    int k = a % 4;
    logic [31:0] b = (rd >> (8 * k)) & 32'hFF;
    logic [31:0] h = (rd >> (8 * k)) & 32'hFFFF;
    case (op)
      LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      LHU:     return h;
      default: return rd;
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit          xfer_seen = 0;
  bit          hold_req = 0, hold_out = 0;
  logic [31:0] p_addr, p_wd, p_od;
  logic [3:0]  p_be;
  logic        p_we;
  logic [7:0]  p_octl;

  always @(negedge clk) begin
    op_t  p;
    res_t r;
    if (!reset_n) begin
      pend_q.delete();
      res_q.delete();
      hold_req  = 0;
      hold_out  = 0;
      xfer_seen = 0;
    end else begin
      if (hold_req) begin
        chk("req_stable", {mem_req, mem_we, mem_be}, {1'b1, p_we, p_be});
        chk("addr_stable", mem_addr, p_addr);
        chk("wdata_stable", mem_wdata, p_wd);
      end
      if (hold_out) begin
        chk("out_stable", {out_valid, out_rd, out_regwrite, out_misalign}, p_octl);
        chk("odata_stable", out_data, p_od);
      end
      if (mem_req) chk("req_with_out", out_valid, 0);

      if (in_valid && in_ready) begin
        p = '{op: in_op, a: in_alu_y, wd: in_wdata, rd: in_rd, rw: in_regwrite};
        if (!ref_mem(p.op))
          res_q.push_back('{d: p.a, rd: p.rd, rw: p.rw, mis: 0, dchk: 1});
        else if (ref_misal(p.op, p.a))
          res_q.push_back('{d: p.a, rd: p.rd, rw: 0, mis: 1, dchk: 1});
        else
          pend_q.push_back(p);
      end

      if (mem_req && mem_ack) begin
        if (pend_q.size() == 0) chk("spurious_req", 1, 0);
        else begin
          p = pend_q.pop_front();
          chk("bus_addr", mem_addr, p.a & 32'hFFFF_FFFC);
          chk("bus_we_be", {mem_we, mem_be}, {(p.op >= SW), ref_be(p.op, p.a)});
          if (p.op >= SW) chk("bus_wdata", mem_wdata, ref_wd(p.op, p.wd));
          if (p.op >= SW)
            res_q.push_back('{d: 0, rd: p.rd, rw: 0, mis: 0, dchk: 0});
          else
            res_q.push_back('{d: ref_ld(p.op, p.a, mem_rdata), rd: p.rd, rw: p.rw,
                              mis: 0, dchk: 1});
        end
      end

      if (out_valid && out_ready) begin
        if (res_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          r = res_q.pop_front();
          chk("wb_ctl", {out_rd, out_regwrite, out_misalign}, {r.rd, r.rw, r.mis});
          if (r.dchk) chk("wb_data", out_data, r.d);
        end
      end

      hold_req  = mem_req & ~mem_ack;
      p_we      = mem_we;
      p_be      = mem_be;
      p_addr    = mem_addr;
      p_wd      = mem_wdata;
      hold_out  = out_valid & ~out_ready;
      p_octl    = {out_valid, out_rd, out_regwrite, out_misalign};
      p_od      = out_data;
      xfer_seen = in_valid & in_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_op(input mem_op_t op, input logic [31:0] y, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rw);
    in_op = op; in_alu_y = y; in_wdata = wd; in_rd = rd; in_regwrite = rw;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] y;
    tick(); tick();
    chk("rst_mem", {mem_req, mem_we, mem_be}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_out", {out_valid, out_rd, out_regwrite, out_misalign}, 0);
    chk("rst_odata", out_data, 0);
    reset_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // NONE pass-through, latency 1
    put_op(NONE, 32'h1234_5678, 32'h0, 5'd3, 1'b1);
    chk("none_ctl", {out_valid, out_rd, out_regwrite, out_misalign}, {1'b1, 5'd3, 1'b1, 1'b0});
    chk("none_data", out_data, 32'h1234_5678);
    tick();

    // LB / LBU at lane 3 with two wait states
    for (int s = 0; s < 2; s++) begin
      put_op(s == 0 ? LB : LBU, 32'h0000_0103, 32'h0, 5'd5, 1'b1);
      chk("lb_req", {mem_req, mem_we, mem_be}, {1'b1, 1'b0, 4'hF});
      chk("lb_addr", mem_addr, 32'h0000_0100);
      tick(); tick();
      mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
      chk("lb_early", out_valid, 0);
      tick();
      mem_ack = 1'b0;
      chk("lb_done", {out_valid, mem_req, out_regwrite}, {1'b1, 1'b0, 1'b1});
      chk(s == 0 ? "lb_data" : "lbu_data", out_data, s == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
      tick();
    end

    // SH upper half
    put_op(SH, 32'h0000_0202, 32'h1234_BEEF, 5'd7, 1'b1);
    chk("sh_req", {mem_req, mem_we, mem_be}, {1'b1, 1'b1, 4'b1100});
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", mem_addr, 32'h0000_0200);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sh_done", {out_valid, out_regwrite, out_misalign}, {1'b1, 1'b0, 1'b0});
    tick();

    // misaligned LW: no bus cycle, latency 1
    put_op(LW, 32'h0000_0101, 32'h0, 5'd4, 1'b1);
    chk("mis_ctl", {mem_req, out_valid, out_misalign, out_regwrite}, 4'b0110);
    chk("mis_data", out_data, 32'h0000_0101);
    tick();

    // back-pressure on a load result
    put_op(LW, 32'h0000_0104, 32'h0, 5'd9, 1'b1);
    out_ready = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    in_op = LW; in_alu_y = 32'h0000_0108; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {out_valid, in_ready, mem_req}, 3'b100);
      chk("bp_data", out_data, 32'hCAFE_F00D);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release", {out_valid, in_ready}, 2'b01);

    // reset while the bus is waiting
    put_op(LW, 32'h0000_0300, 32'h0, 5'd1, 1'b1);
    chk("rst_mid_req", mem_req, 1);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_drop", mem_req, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst_mid_after", {out_valid, in_ready, mem_req}, 3'b010);

    // randomized traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!in_valid || xfer_seen) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = mem_op_t'($urandom_range(0, 8));
        y        = $urandom;
        if ($urandom_range(0, 1) == 0) y[1:0] = 2'b00;
        in_alu_y = y;
        in_wdata = $urandom;
        in_rd    = 5'($urandom_range(0, 31));
        in_regwrite = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      mem_ack   = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end

    // drain, bounded
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && (pend_q.size() + res_q.size() != 0 || out_valid); c++) begin
      mem_ack = mem_req;
      mem_rdata = $urandom;
      tick();
    end
    mem_ack = 1'b0;
    chk("drain_empty", pend_q.size() + res_q.size(), 0);
    chk("drain_idle", {out_valid, mem_req, in_ready}, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
